// File: rtl/nes_pad_responder.sv
// NES pad emulator: 4021-style shift register answering host latch/pulse.
// Define TURBO_EN to add turbo_mask autofire masking on alternate windows.
module nes_pad_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    lvl_d  = lvl_q;
    cnt_d  = '0;
    if (s != lvl_q) begin
      if (cnt_q == CMAX) lvl_d = s;
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  assign lvl_o = lvl_q;

endmodule

module nes_pad_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 3_000_000
`ifdef TURBO_EN
  ,
  parameter int TURBO_FRAMES   = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       latch_in,
  input  logic       pulse_in,
  input  logic [7:0] buttons,
`ifdef TURBO_EN
  input  logic [7:0] turbo_mask,
`endif
  output logic       data_out,
  output logic       frame_strobe,
  output logic       shifting,
  output logic       link_lost
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        fstb_q, fstb_d;
  logic        lost_q, lost_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic        latch_prev_q, pulse_prev_q;
  logic        latch_f, pulse_f;
  logic        latch_rise, pulse_rise;
  logic [7:0]  load_val;

  nes_pad_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_latch_flt (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (latch_in),
    .lvl_o(latch_f)
  );

  nes_pad_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_pulse_flt (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (pulse_in),
    .lvl_o(pulse_f)
  );

  assign latch_rise = latch_f & ~latch_prev_q;
  assign pulse_rise = pulse_f & ~pulse_prev_q;

`ifdef TURBO_EN
  localparam int FW = $clog2(TURBO_FRAMES + 1);
  localparam logic [FW-1:0] FMAX = FW'(TURBO_FRAMES - 1);

  logic [FW-1:0] frm_q, frm_d;
  logic          phase_q, phase_d;

  assign load_val = buttons & ~(turbo_mask & {8{phase_q}});

  always_comb begin
    frm_d   = frm_q;
    phase_d = phase_q;
    if (fstb_d) begin
      if (frm_q == FMAX) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      frm_q   <= frm_d;
      phase_q <= phase_d;
    end
  end
`else
  assign load_val = buttons;
`endif

  // Latch level overrides everything: parallel-load mode of the 4021.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    fstb_d    = 1'b0;
    if (latch_f) begin
      state_d   = LOAD;
      shreg_d   = load_val;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          state_d = SHIFT;
          fstb_d  = 1'b1;
        end
        SHIFT: begin
          if (pulse_rise) begin
            shreg_d   = {shreg_q[6:0], 1'b1};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    lost_d   = lost_q;
    if (latch_rise) begin
      to_cnt_d = '0;
      lost_d   = 1'b0;
    end else begin
      if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TW'(1);
      lost_d = lost_q | (to_cnt_q >= TO_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= 8'h00;
      bit_cnt_q    <= '0;
      fstb_q       <= 1'b0;
      lost_q       <= 1'b1;
      to_cnt_q     <= '0;
      latch_prev_q <= 1'b0;
      pulse_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      fstb_q       <= fstb_d;
      lost_q       <= lost_d;
      to_cnt_q     <= to_cnt_d;
      latch_prev_q <= latch_f;
      pulse_prev_q <= pulse_f;
    end
  end

  always_comb begin
    data_out = 1'b1;
    unique case (state_q)
      IDLE:  data_out = 1'b1;
      LOAD:  data_out = ~shreg_q[7];
      SHIFT: data_out = ~shreg_q[7];
      DONE:  data_out = 1'b0;
      default: data_out = 1'b1;
    endcase
  end

  assign frame_strobe = fstb_q;
  assign shifting     = (state_q == SHIFT);
  assign link_lost    = lost_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder (TIMEOUT_CYCLES=100).
// With TURBO_EN defined it also exercises turbo masking.
module tb_nes_pad_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       latch_in = 1'b0;
  logic       pulse_in = 1'b0;
  logic [7:0] buttons = 8'h00;
`ifdef TURBO_EN
  logic [7:0] turbo_mask = 8'h00;
`endif
  logic       data_out;
  logic       frame_strobe;
  logic       shifting;
  logic       link_lost;

  int n_chk = 0;
  int n_err = 0;
  int fs_cnt = 0;

  always #5 clk = ~clk;

  nes_pad_responder #(
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (2),
`ifdef TURBO_EN
    .TURBO_FRAMES  (1),
`endif
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .latch_in    (latch_in),
    .pulse_in    (pulse_in),
    .buttons     (buttons),
`ifdef TURBO_EN
    .turbo_mask  (turbo_mask),
`endif
    .data_out    (data_out),
    .frame_strobe(frame_strobe),
    .shifting    (shifting),
    .link_lost   (link_lost)
  );

  always @(negedge clk)
    if (rst_n && frame_strobe === 1'b1) fs_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_open(input logic [7:0] b);
    buttons  = b;
    latch_in = 1'b1;
    tick(20);
    latch_in = 1'b0;
    tick(5);
  endtask

  task automatic pulse();
    pulse_in = 1'b1;
    tick(5);
    pulse_in = 1'b0;
    tick(5);
  endtask

  logic [7:0] exp_b;
  logic       e;

  initial begin
    tick(3);
    chk("rst_data", data_out, 1);
    chk("rst_shift", shifting, 0);
    chk("rst_lost", link_lost, 1);
    chk("rst_fstb", frame_strobe, 0);
    rst_n = 1'b1;
    tick(10);
    chk("idle_data", data_out, 1);
    chk("idle_shift", shifting, 0);
    chk("idle_lost", link_lost, 1);
    chk("idle_fs", fs_cnt, 0);

    // normal frame, A/Select/Right pressed
    exp_b    = 8'hA1;
    buttons  = exp_b;
    latch_in = 1'b1;
    tick(4);
    chk("lat_lat4", data_out, 1);
    tick(1);
    chk("lat_lat5", data_out, 0);
    chk("lat_shift", shifting, 0);
    buttons = 8'h21;
    tick(1);
    chk("transparent", data_out, 1);
    buttons = exp_b;
    tick(14);
    latch_in = 1'b0;
    tick(4);
    chk("fall_lat4", shifting, 0);
    tick(1);
    chk("fall_shift", shifting, 1);
    chk("fall_fstb", frame_strobe, 1);
    chk("fall_A", data_out, 0);
    tick(1);
    chk("fstb_1cyc", frame_strobe, 0);
    for (int i = 0; i < 8; i++) begin
      e = ~exp_b[7-i];
      chk($sformatf("bit%0d", i), data_out, e);
      pulse();
    end
    chk("done_data", data_out, 0);
    chk("done_shift", shifting, 0);
    pulse();
    pulse();
    chk("over_data", data_out, 0);
    chk("fs_one", fs_cnt, 1);

    // abort mid-shift
    frame_open(8'h00);
    pulse();
    pulse();
    pulse();
    chk("ab_bit3", data_out, 1);
    buttons = 8'hFF;
    tick(10);
    chk("frozen", data_out, 1);
    latch_in = 1'b1;
    tick(4);
    chk("ab_lat4", data_out, 1);
    tick(1);
    chk("ab_lat5", data_out, 0);
    chk("ab_shift", shifting, 0);
    tick(15);
    chk("ab_no_fs", fs_cnt, 2);
    latch_in = 1'b0;
    tick(5);
    chk("ab_reshift", shifting, 1);
    for (int i = 0; i < 7; i++) pulse();
    chk("restart_sh", shifting, 1);
    chk("restart_d", data_out, 0);
    pulse();
    chk("ab_done_sh", shifting, 0);
    chk("ab_done_d", data_out, 0);
    chk("ab_fs", fs_cnt, 3);

    // glitch rejection
    frame_open(8'h80);
    chk("gl_A", data_out, 0);
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(10);
    chk("glitch_d", data_out, 0);
    chk("glitch_sh", shifting, 1);
    pulse();
    chk("gl_B", data_out, 1);

    // latch and pulse rising together
    latch_in = 1'b1;
    pulse_in = 1'b1;
    tick(5);
    chk("both_sh", shifting, 0);
    chk("both_d", data_out, 0);
    tick(5);
    pulse_in = 1'b0;
    tick(5);
    pulse_in = 1'b1;
    tick(5);
    chk("pl_latch_d", data_out, 0);
    chk("pl_latch_sh", shifting, 0);
    pulse_in = 1'b0;
    latch_in = 1'b0;
    tick(5);
    chk("both_A", data_out, 0);
    pulse();
    chk("both_B", data_out, 1);

    // async reset mid-frame
    frame_open(8'hFF);
    chk("pre_rst_d", data_out, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_d", data_out, 1);
    chk("arst_sh", shifting, 0);
    chk("arst_lost", link_lost, 1);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // link timeout
    tick(120);
    chk("to_lost0", link_lost, 1);
    latch_in = 1'b1;
    tick(4);
    chk("to_lat4", link_lost, 1);
    tick(1);
    chk("to_clr", link_lost, 0);
    tick(5);
    latch_in = 1'b0;
    tick(70);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("to_per%0d", i), link_lost, 0);
      latch_in = 1'b1;
      tick(5);
      chk($sformatf("to_rise%0d", i), link_lost, 0);
      tick(5);
      latch_in = 1'b0;
      tick(70);
    end
    latch_in = 1'b1;
    tick(5);
    tick(5);
    latch_in = 1'b0;
    tick(94);
    chk("to_99", link_lost, 0);
    tick(1);
    chk("to_100", link_lost, 1);
    latch_in = 1'b1;
    tick(5);
    chk("to_again", link_lost, 0);
    tick(5);
    latch_in = 1'b0;
    tick(10);

`ifdef TURBO_EN
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    turbo_mask = 8'h80;
    buttons    = 8'h80;
    for (int f = 0; f < 3; f++) begin
      latch_in = 1'b1;
      tick(6);
      e = (f == 1);
      chk($sformatf("turbo%0d", f), data_out, e);
      tick(10);
      latch_in = 1'b0;
      tick(10);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
